// File: rtl/set_assoc_cache_ctrl_if.sv
// Bundle of CPU, tag-compare, array-strobe and memory handshake signals for
// set_assoc_cache_ctrl. master = surrounding datapath/CPU/memory side,
// slave = the controller.
interface set_assoc_cache_ctrl_if #(
  parameter int unsigned IDX_W = 3
);
  logic             cpu_req;
  logic             cpu_wr;
  logic [IDX_W-1:0] cpu_index;
  logic             hit0;
  logic             hit1;
  logic             cpu_ready;
  logic             busy;
  logic [IDX_W-1:0] set_sel;
  logic [1:0]       way_we;
  logic [1:0]       tag_we;
  logic             fill_sel;
  logic             mem_req;
  logic             mem_we;
  logic             mem_ack;
  logic [15:0]      hit_count;
  logic [15:0]      miss_count;

  modport master (
    output cpu_req, cpu_wr, cpu_index, hit0, hit1, mem_ack,
    input  cpu_ready, busy, set_sel, way_we, tag_we, fill_sel, mem_req, mem_we,
           hit_count, miss_count
  );

  modport slave (
    input  cpu_req, cpu_wr, cpu_index, hit0, hit1, mem_ack,
    output cpu_ready, busy, set_sel, way_we, tag_we, fill_sel, mem_req, mem_we,
           hit_count, miss_count
  );
endinterface

// File: rtl/set_assoc_cache_ctrl.sv
// Sequencing controller for a 2-way set-associative cache built from D_ff_Mem
// arrays: one access at a time, single-beat refill on read miss, write-through
// on every write (no write-allocate), one LRU bit per set.
// Optional macro CACHE_STATS_EN: enables saturating 16-bit hit/miss counters;
// when undefined the counters are tied to zero.
module set_assoc_cache_ctrl #(
  parameter int unsigned SETS  = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  set_assoc_cache_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {StIdle, StLookup, StRefill, StWthru, StDone} state_e;

  state_e           state_q, state_d;
  logic             wr_q, wr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             victim_q, victim_d;
  // lru_q[s] names the least recently used way of set s
  logic [SETS-1:0]  lru_q, lru_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;

  logic       hit_any;
  logic       hit_way;
  logic [1:0] way_we;
  logic [1:0] tag_we;
  logic       fill_sel;
  logic       cpu_ready;
  logic       lookup_hit;
  logic       lookup_miss;

  // Both hit lines set resolves to way 0
  assign hit_any = bus.hit0 | bus.hit1;
  assign hit_way = ~bus.hit0;

  // State, latched request and registered memory handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      wr_q      <= 1'b0;
      idx_q     <= '0;
      victim_q  <= 1'b0;
      lru_q     <= '0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      idx_q     <= idx_d;
      victim_q  <= victim_d;
      lru_q     <= lru_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
    end
  end

  // Next-state, LRU update and combinational array strobes
  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    idx_d       = idx_q;
    victim_d    = victim_q;
    lru_d       = lru_q;
    way_we      = 2'b00;
    tag_we      = 2'b00;
    fill_sel    = 1'b0;
    cpu_ready   = 1'b0;
    lookup_hit  = 1'b0;
    lookup_miss = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.cpu_req) begin
          wr_d    = bus.cpu_wr;
          idx_d   = bus.cpu_index;
          state_d = StLookup;
        end
      end
      StLookup: begin
        if (hit_any) begin
          lookup_hit    = 1'b1;
          lru_d[idx_q]  = ~hit_way;
          if (wr_q) begin
            way_we[hit_way] = 1'b1;
            state_d         = StWthru;
          end else begin
            cpu_ready = 1'b1;
            state_d   = StIdle;
          end
        end else begin
          lookup_miss = 1'b1;
          if (wr_q) begin
            state_d = StWthru;
          end else begin
            victim_d = lru_q[idx_q];
            state_d  = StRefill;
          end
        end
      end
      StRefill: begin
        if (bus.mem_ack) begin
          way_we[victim_q] = 1'b1;
          tag_we[victim_q] = 1'b1;
          fill_sel         = 1'b1;
          lru_d[idx_q]     = ~victim_q;
          state_d          = StDone;
        end
      end
      StWthru: begin
        if (bus.mem_ack) state_d = StDone;
      end
      StDone: begin
        cpu_ready = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Registered so mem_req/mem_we rise on entry and drop on the ack edge
    mem_req_d = (state_d == StRefill) || (state_d == StWthru);
    mem_we_d  = (state_d == StWthru);
  end

  assign bus.cpu_ready = cpu_ready;
  assign bus.busy      = (state_q != StIdle);
  assign bus.set_sel   = idx_q;
  assign bus.way_we    = way_we;
  assign bus.tag_we    = tag_we;
  assign bus.fill_sel  = fill_sel;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;

`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;

  // Saturating lookup statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (lookup_hit && (hit_cnt_q != 16'hFFFF))   hit_cnt_q  <= hit_cnt_q + 16'd1;
      if (lookup_miss && (miss_cnt_q != 16'hFFFF)) miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  assign bus.hit_count  = hit_cnt_q;
  assign bus.miss_count = miss_cnt_q;
`else
  logic unused_stats;
  assign unused_stats   = lookup_hit ^ lookup_miss;
  assign bus.hit_count  = 16'h0000;
  assign bus.miss_count = 16'h0000;
`endif

endmodule

// File: tb/tb_set_assoc_cache_ctrl.sv
// Directed bench for set_assoc_cache_ctrl: hits, misses, LRU victim choice,
// write-through, reset mid-refill, dual-hit priority and ignored requests.
module tb_set_assoc_cache_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   exp_hit = 0;
  int   exp_miss = 0;

  always #5 clk = ~clk;

  set_assoc_cache_ctrl_if #(.IDX_W(3)) bus ();

  set_assoc_cache_ctrl #(.SETS(8), .IDX_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int cnt_exp(input int v);
`ifdef CACHE_STATS_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_hit_count"}, {16'h0, bus.hit_count}, cnt_exp(exp_hit));
    chk({tag, "_miss_count"}, {16'h0, bus.miss_count}, cnt_exp(exp_miss));
  endtask

  // Issue one request from IDLE; returns in the LOOKUP cycle with hits cleared
  task automatic start(input logic wr, input logic [2:0] idx);
    bus.cpu_req   = 1'b1;
    bus.cpu_wr    = wr;
    bus.cpu_index = idx;
    step();
    bus.cpu_req   = 1'b0;
    bus.hit0      = 1'b0;
    bus.hit1      = 1'b0;
  endtask

  // Miss (read -> refill, write -> write-through) with ack_wait idle memory cycles
  task automatic run_miss(input logic wr, input logic [2:0] idx, input logic [1:0] exp_we,
                          input int ack_wait, input logic poke);
    start(wr, idx);
    #1;
    chk("miss_lookup_ready", bus.cpu_ready, 0);
    chk("miss_lookup_way_we", bus.way_we, 0);
    chk("miss_lookup_mem_req", bus.mem_req, 0);
    chk("miss_lookup_set_sel", bus.set_sel, idx);
    exp_miss++;
    for (int i = 0; i < ack_wait; i++) begin
      step();
      bus.cpu_req = poke;
      bus.cpu_index = 3'd7;
      #1;
      chk("miss_wait_mem_req", bus.mem_req, 1);
      chk("miss_wait_mem_we", bus.mem_we, wr);
      chk("miss_wait_way_we", bus.way_we, 0);
      chk("miss_wait_ready", bus.cpu_ready, 0);
    end
    step();
    bus.cpu_req = 1'b0;
    bus.mem_ack = 1'b1;
    #1;
    chk("miss_ack_mem_req", bus.mem_req, 1);
    chk("miss_ack_way_we", bus.way_we, wr ? 2'b00 : exp_we);
    chk("miss_ack_tag_we", bus.tag_we, wr ? 2'b00 : exp_we);
    chk("miss_ack_fill_sel", bus.fill_sel, wr ? 0 : 1);
    chk("miss_ack_ready", bus.cpu_ready, 0);
    step();
    bus.mem_ack = 1'b0;
    #1;
    chk("miss_done_ready", bus.cpu_ready, 1);
    chk("miss_done_mem_req", bus.mem_req, 0);
    chk("miss_done_busy", bus.busy, 1);
    chk("miss_done_way_we", bus.way_we, 0);
    step();
    #1;
    chk("miss_idle_busy", bus.busy, 0);
    chk("miss_idle_ready", bus.cpu_ready, 0);
    chk_counts("miss_idle");
  endtask

  initial begin
    bus.cpu_req   = 1'b0;
    bus.cpu_wr    = 1'b0;
    bus.cpu_index = 3'd0;
    bus.hit0      = 1'b0;
    bus.hit1      = 1'b0;
    bus.mem_ack   = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_ready", bus.cpu_ready, 0);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_way_we", bus.way_we, 0);
    chk("rst_tag_we", bus.tag_we, 0);
    chk("rst_fill_sel", bus.fill_sel, 0);
    chk("rst_set_sel", bus.set_sel, 0);
    chk_counts("rst");

    // Read hit on way 1 of set 3
    start(1'b0, 3'd3);
    bus.hit1 = 1'b1;
    #1;
    chk("rdhit_ready", bus.cpu_ready, 1);
    chk("rdhit_busy", bus.busy, 1);
    chk("rdhit_set_sel", bus.set_sel, 3);
    chk("rdhit_way_we", bus.way_we, 0);
    chk("rdhit_mem_req", bus.mem_req, 0);
    exp_hit++;
    step();
    bus.hit1 = 1'b0;
    #1;
    chk("rdhit_idle_busy", bus.busy, 0);
    chk("rdhit_idle_mem_req", bus.mem_req, 0);
    chk_counts("rdhit");

    // Read misses to set 5: way 0 first, then way 1
    run_miss(1'b0, 3'd5, 2'b01, 2, 1'b0);
    run_miss(1'b0, 3'd5, 2'b10, 0, 1'b0);

    // Set 3 was hit on way 1, so way 0 is its victim
    run_miss(1'b0, 3'd3, 2'b01, 0, 1'b0);

    // Write hit on way 0 of set 2
    start(1'b1, 3'd2);
    bus.hit0 = 1'b1;
    #1;
    chk("wrhit_way_we", bus.way_we, 2'b01);
    chk("wrhit_tag_we", bus.tag_we, 0);
    chk("wrhit_fill_sel", bus.fill_sel, 0);
    chk("wrhit_ready", bus.cpu_ready, 0);
    chk("wrhit_mem_req", bus.mem_req, 0);
    exp_hit++;
    step();
    bus.hit0 = 1'b0;
    #1;
    chk("wrhit_wt_mem_req", bus.mem_req, 1);
    chk("wrhit_wt_mem_we", bus.mem_we, 1);
    chk("wrhit_wt_way_we", bus.way_we, 0);
    step();
    bus.mem_ack = 1'b1;
    #1;
    chk("wrhit_ack_mem_req", bus.mem_req, 1);
    chk("wrhit_ack_mem_we", bus.mem_we, 1);
    chk("wrhit_ack_ready", bus.cpu_ready, 0);
    chk("wrhit_ack_way_we", bus.way_we, 0);
    step();
    bus.mem_ack = 1'b0;
    #1;
    chk("wrhit_done_ready", bus.cpu_ready, 1);
    chk("wrhit_done_mem_req", bus.mem_req, 0);
    chk("wrhit_done_mem_we", bus.mem_we, 0);
    step();
    #1;
    chk("wrhit_idle_busy", bus.busy, 0);
    chk_counts("wrhit");

    // Write miss to set 2 leaves LRU[2] pointing at way 1; the read miss proves it
    run_miss(1'b1, 3'd2, 2'b00, 1, 1'b0);
    run_miss(1'b0, 3'd2, 2'b10, 0, 1'b0);

    // Reset during refill, then a stray ack
    start(1'b0, 3'd6);
    step();
    #1;
    chk("rstmid_mem_req_before", bus.mem_req, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.mem_ack = 1'b1;
    exp_hit = 0;
    exp_miss = 0;
    #1;
    chk("rstmid_mem_req", bus.mem_req, 0);
    chk("rstmid_busy", bus.busy, 0);
    chk("rstmid_way_we", bus.way_we, 0);
    chk("rstmid_tag_we", bus.tag_we, 0);
    chk_counts("rstmid");
    step();
    #1;
    chk("stray_ack_busy", bus.busy, 0);
    chk("stray_ack_ready", bus.cpu_ready, 0);
    chk("stray_ack_way_we", bus.way_we, 0);
    chk("stray_ack_mem_req", bus.mem_req, 0);
    bus.mem_ack = 1'b0;

    // Both hit lines on a read: way 0 hit, so way 1 becomes the victim
    start(1'b0, 3'd4);
    bus.hit0 = 1'b1;
    bus.hit1 = 1'b1;
    #1;
    chk("dualhit_ready", bus.cpu_ready, 1);
    chk("dualhit_way_we", bus.way_we, 0);
    exp_hit++;
    step();
    bus.hit0 = 1'b0;
    bus.hit1 = 1'b0;
    // Miss with cpu_req held during refill: must be ignored
    run_miss(1'b0, 3'd4, 2'b10, 2, 1'b1);
    step();
    #1;
    chk("poke_not_queued_busy", bus.busy, 0);
    chk("poke_not_queued_ready", bus.cpu_ready, 0);

    // LRU of set 5 was cleared by reset
    run_miss(1'b0, 3'd5, 2'b01, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/set_assoc_cache_ctrl.md
# set_assoc_cache_ctrl

Sequencing controller for the 2-way set-associative cache data/tag arrays built from `D_ff_Mem` word storage. It accepts one CPU access at a time and evaluates the external tag-compare hit lines. It drives the per-way array write strobes and runs a single-beat refill or write-through handshake with main memory. It keeps one LRU bit per set for victim selection.

## Interface
Parameters:
- SETS, 8, number of sets; power of two, at least 2
- IDX_W, 3, index width; must equal log2(SETS)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears FSM, LRU and counters
- cpu_req  in  1  access request; sampled only in IDLE
- cpu_wr  in  1  1 = write, 0 = read; sampled with cpu_req
- cpu_index  in  IDX_W  set index; sampled with cpu_req
- hit0, hit1  in  1  valid-qualified tag match for way 0 and way 1; meaningful in LOOKUP only
- cpu_ready  out  1  one-cycle completion pulse
- busy  out  1  high in every state except IDLE
- set_sel  out  IDX_W  latched index driven to the arrays (decOut source)
- way_we  out  2  per-way data write strobe (memWrite)
- tag_we  out  2  per-way tag/valid write strobe
- fill_sel  out  1  array data source: 0 = CPU write data, 1 = memory refill data
- mem_req  out  1  memory request; held until acknowledged
- mem_we  out  1  memory write (write-through) when 1, read (refill) when 0
- mem_ack  in  1  one-cycle memory acknowledge
- hit_count, miss_count  out  16  statistics (see Configuration)

## Operation
FSM states: IDLE, LOOKUP, REFILL, WTHRU, DONE.
- IDLE: when cpu_req=1, latch cpu_wr and cpu_index into set_sel, then go to LOOKUP. When cpu_req=0, stay in IDLE.
- LOOKUP, read with a hit: pulse cpu_ready, set LRU[set] so the hit way becomes most recently used, then go to IDLE.
- LOOKUP, read with a miss: latch victim = LRU[set] (LRU bit value names the least recently used way), then go to REFILL.
- LOOKUP, write with a hit: assert way_we[hit way] with fill_sel=0 in this cycle, update LRU, then go to WTHRU.
- LOOKUP, write with a miss: no array write and no LRU change (no write-allocate); go to WTHRU.
- If hit0 and hit1 are both 1, treat it as a hit on way 0.
- REFILL: mem_req=1, mem_we=0. On mem_ack, assert way_we[victim] and tag_we[victim] with fill_sel=1, make victim most recently used, then go to DONE.
- WTHRU: mem_req=1, mem_we=1. On mem_ack, go to DONE.
- DONE: pulse cpu_ready, then go to IDLE.
- way_we, tag_we and fill_sel are 0 in all other state/input combinations.
- cpu_req while busy=1 is ignored and not queued.
- mem_ack outside REFILL/WTHRU is ignored.

## Timing
- Reset values:
  - state = IDLE; LRU = 0 for all sets (way 0 is the first victim); counters = 0.
  - cpu_ready, busy, way_we, tag_we, fill_sel, mem_req, mem_we = 0; set_sel = 0.
- mem_req and mem_we are registered and rise in the first cycle of REFILL/WTHRU. mem_ack is accepted in that same cycle at the earliest.
- way_we and tag_we are combinational from state and the hit/ack inputs.
- Latency, with the request sampled at edge 0:
  - read hit: cpu_ready in cycle 1.
  - miss or write: cpu_ready one cycle after the cycle in which mem_ack is seen.
  - best case for miss or write: ready in cycle 3.
- No timeout; REFILL/WTHRU wait indefinitely for mem_ack.
- Reset asserted mid-transaction: next cycle is IDLE with mem_req=0 and no strobes; the pending access is dropped.
- Back-to-back: a new cpu_req is accepted in the IDLE cycle that immediately follows cpu_ready.

## Configuration
- CACHE_STATS_EN defined:
  - hit_count increments on each LOOKUP hit (read or write).
  - miss_count increments on each LOOKUP miss.
  - both saturate at 16'hFFFF and clear on reset.
- CACHE_STATS_EN undefined: counter logic is removed; hit_count and miss_count are tied to 0.

## Test plan
- Reset, then read index 3 with hit1=1 in LOOKUP: cpu_ready in cycle 1, no mem_req, LRU[3] points to way 0, hit_count=1.
- Read index 5 with both hits 0, mem_ack 2 cycles after mem_req rises:
  - victim is way 0; way_we=2'b01, tag_we=2'b01, fill_sel=1 in the ack cycle; cpu_ready the next cycle; miss_count=1.
  - a second miss to index 5 selects way 1.
- Write to index 2 with hit0=1: way_we=2'b01, fill_sel=0 in LOOKUP; mem_req=1, mem_we=1 until ack; cpu_ready one cycle after ack.
- Write miss to index 2: way_we stays 0 throughout; the write-through completes; LRU[2] unchanged.
- Assert reset during REFILL before mem_ack: next cycle mem_req=0, busy=0, no strobes. A subsequent mem_ack is ignored.
- Hold hit0=hit1=1 on a read: behaves as a way-0 hit. Drive cpu_req during REFILL: ignored, exactly one cpu_ready. With CACHE_STATS_EN undefined, counters read 0 throughout.
